// File: rtl/led_round_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_round_tracker                                      |
// | Description : Round-progress timer. Fills a thermometer LED bar at a |
// |               difficulty-dependent rate, pulses a timeout when the   |
// |               bar is full and counts rounds passed (saturating).     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module led_round_tracker #(
  parameter int TICK_DIV  = 5000000,  // Clk cycles per base tick
  parameter int NUM_LEDS  = 10,       // bar length / steps per round
  parameter int PERIOD_D0 = 10,       // ticks per step, difficulty 0
  parameter int PERIOD_D1 = 8,        // ticks per step, difficulty 1
  parameter int PERIOD_D2 = 6,        // ticks per step, difficulty 2
  parameter int PERIOD_D3 = 4         // ticks per step, difficulty 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                NewGamePulse,
  input  logic                EnableGameElements,
  input  logic [1:0]          Difficulty,
  input  logic                CrashDetected,
  output logic                LEDTrackerTimeOut,
  output logic [NUM_LEDS-1:0] LEDs,
  output logic                RoundActive,
  output logic                StepPulse,
  output logic [3:0]          RoundsPassed
);

  // Counter widths: the prescaler must hold TICK_DIV-1, the step counter
  // must hold NUM_LEDS (it reaches NUM_LEDS on the final step).
  localparam int c_pre_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_step_w = $clog2(NUM_LEDS + 1);

  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(NUM_LEDS - 1);
  localparam logic [3:0]          c_rounds_max = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q,      state_d;
  logic [c_pre_w-1:0]    prescale_q,   prescale_d;
  logic [3:0]            tick_cnt_q,   tick_cnt_d;
  logic [c_step_w-1:0]   step_cnt_q,   step_cnt_d;
  logic [3:0]            period_q,     period_d;
  logic [NUM_LEDS-1:0]   leds_q,       leds_d;
  logic                  timeout_q,    timeout_d;
  logic                  active_q,     active_d;
  logic                  step_seen_q,  step_seen_d;
  logic                  step_pulse_q, step_pulse_d;
  logic [3:0]            rounds_q,     rounds_d;

  logic                  w_tick;
  logic                  w_step;

  // Ticks per LED step for a given difficulty; latched at round start.
  function automatic logic [3:0] period_for(input logic [1:0] diff);
    logic [3:0] p;
    case (diff)
      2'd0:    p = 4'(PERIOD_D0);
      2'd1:    p = 4'(PERIOD_D1);
      2'd2:    p = 4'(PERIOD_D2);
      default: p = 4'(PERIOD_D3);
    endcase
    return p;
  endfunction

  // Base tick and LED step strobes, only meaningful while running.
  assign w_tick = (state_q == ST_RUN) && (prescale_q == c_pre_last);
  assign w_step = w_tick && (tick_cnt_q == (period_q - 4'd1));

  // Next-state and next-output logic; NewGamePulse overrides everything.
  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    tick_cnt_d   = tick_cnt_q;
    step_cnt_d   = step_cnt_q;
    period_d     = period_q;
    leds_d       = leds_q;
    rounds_d     = rounds_q;
    timeout_d    = 1'b0;
    step_seen_d  = 1'b0;
    // StepPulse trails the LED advance by one cycle.
    step_pulse_d = step_seen_q;

    if (NewGamePulse) begin
      state_d      = ST_IDLE;
      prescale_d   = '0;
      tick_cnt_d   = '0;
      step_cnt_d   = '0;
      leds_d       = '0;
      rounds_d     = '0;
      step_pulse_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          leds_d     = '0;
          prescale_d = '0;
          tick_cnt_d = '0;
          step_cnt_d = '0;
          if (EnableGameElements) begin
            state_d  = ST_RUN;
            period_d = period_for(Difficulty);
          end
        end

        ST_RUN: begin
          if (CrashDetected) begin
            // Crash wins over a coincident step: LEDs keep their value.
            state_d = ST_DONE;
          end else if (!EnableGameElements) begin
            state_d    = ST_IDLE;
            leds_d     = '0;
            prescale_d = '0;
            tick_cnt_d = '0;
            step_cnt_d = '0;
          end else begin
            prescale_d = w_tick ? '0 : (prescale_q + 1'b1);
            if (w_step) begin
              tick_cnt_d  = '0;
              step_cnt_d  = step_cnt_q + 1'b1;
              leds_d      = {leds_q[NUM_LEDS-2:0], 1'b1};
              step_seen_d = 1'b1;
              if (step_cnt_q == c_step_last) begin
                timeout_d = 1'b1;
                rounds_d  = (rounds_q == c_rounds_max) ? rounds_q
                                                       : (rounds_q + 4'd1);
                state_d   = ST_DONE;
              end
            end else if (w_tick) begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end

        ST_DONE: begin
          if (!EnableGameElements) begin
            state_d    = ST_IDLE;
            leds_d     = '0;
            prescale_d = '0;
            tick_cnt_d = '0;
            step_cnt_d = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          leds_d  = '0;
        end
      endcase
    end

    active_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      prescale_q   <= '0;
      tick_cnt_q   <= '0;
      step_cnt_q   <= '0;
      period_q     <= 4'(PERIOD_D0);
      leds_q       <= '0;
      timeout_q    <= 1'b0;
      active_q     <= 1'b0;
      step_seen_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      rounds_q     <= '0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      tick_cnt_q   <= tick_cnt_d;
      step_cnt_q   <= step_cnt_d;
      period_q     <= period_d;
      leds_q       <= leds_d;
      timeout_q    <= timeout_d;
      active_q     <= active_d;
      step_seen_q  <= step_seen_d;
      step_pulse_q <= step_pulse_d;
      rounds_q     <= rounds_d;
    end
  end

  assign LEDTrackerTimeOut = timeout_q;
  assign LEDs              = leds_q;
  assign RoundActive       = active_q;
  assign StepPulse         = step_pulse_q;
  assign RoundsPassed      = rounds_q;

endmodule
`default_nettype wire

// File: tb/tb_led_round_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_led_round_tracker                                   |
// | Description : Scoreboard bench for led_round_tracker. A schedule     |
// |               model predicts StepPulse/timeout events per round; a   |
// |               monitor pops and compares them as they appear.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_led_round_tracker;

  localparam int TD = 2;   // TICK_DIV under test
  localparam int NL = 4;   // NUM_LEDS under test

  localparam int K_FULL    = 0;
  localparam int K_CRASH   = 1;
  localparam int K_ABORT   = 2;
  localparam int K_NEWGAME = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          NewGamePulse = 1'b0;
  logic          EnableGameElements = 1'b0;
  logic [1:0]    Difficulty = 2'd0;
  logic          CrashDetected = 1'b0;
  logic          LEDTrackerTimeOut;
  logic [NL-1:0] LEDs;
  logic          RoundActive;
  logic          StepPulse;
  logic [3:0]    RoundsPassed;

  led_round_tracker #(
    .TICK_DIV (TD),
    .NUM_LEDS (NL)
  ) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .NewGamePulse       (NewGamePulse),
    .EnableGameElements (EnableGameElements),
    .Difficulty         (Difficulty),
    .CrashDetected      (CrashDetected),
    .LEDTrackerTimeOut  (LEDTrackerTimeOut),
    .LEDs               (LEDs),
    .RoundActive        (RoundActive),
    .StepPulse          (StepPulse),
    .RoundsPassed       (RoundsPassed)
  );

  always #5 Clk = ~Clk;

  // Clock period index: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int       at;
    bit       to;
    bit       sp;
    int       leds;
    int       rounds;
  } ev_t;

  ev_t exp_q[$];
  int  rounds_m = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int period_of(input int d);
    case (d)
      0:       return 10;
      1:       return 8;
      2:       return 6;
      default: return 4;
    endcase
  endfunction

  // Schedule model: step i lights i LEDs in RUN cycle i*P*TD, its StepPulse
  // follows one cycle later; the full bar times out in cycle NL*P*TD.
  task automatic push_model(input int start, input int p, input int kind,
                            input int at, output int nsteps);
    int  l;
    ev_t e;
    l = p * TD;
    nsteps = 0;
    for (int i = 1; i <= NL; i++) begin
      int ti;
      bit occurs;
      bit pulse;
      ti = i * l;
      if (kind == K_FULL) begin
        occurs = 1'b1; pulse = 1'b1;
      end else if (kind == K_CRASH) begin
        occurs = (ti <= at); pulse = occurs;
      end else begin
        occurs = (ti <= at); pulse = (ti < at);
      end
      if (occurs) nsteps = i;
      if (kind == K_FULL && i == NL) begin
        rounds_m = (rounds_m < 15) ? rounds_m + 1 : 15;
        e.at = start + ti; e.to = 1'b1; e.sp = 1'b0;
        e.leds = (1 << NL) - 1; e.rounds = rounds_m;
        exp_q.push_back(e);
      end
      if (pulse) begin
        e.at = start + ti + 1; e.to = 1'b0; e.sp = 1'b1;
        e.leds = (1 << i) - 1; e.rounds = rounds_m;
        exp_q.push_back(e);
      end
    end
    if (kind == K_NEWGAME) rounds_m = 0;
  endtask

  // Monitor: flag overdue predictions, then match each presented event.
  always @(negedge Clk) begin
    if (Reset) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        check("missed_event", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (StepPulse || LEDTrackerTimeOut) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(StepPulse) + int'(LEDTrackerTimeOut), 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_cycle",   cyc, e.at);
          check("timeout_flag",  int'(LEDTrackerTimeOut), int'(e.to));
          check("steppulse_flag", int'(StepPulse), int'(e.sp));
          check("event_leds",    int'(LEDs), e.leds);
          check("event_rounds",  int'(RoundsPassed), e.rounds);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Called in the cycle before RUN cycle 0 (start); returns in IDLE.
  task automatic play_round(input int start, input int p, input int kind,
                            input int at, input bit force_d3, input int chain_diff);
    int  nsteps;
    int  l;
    int  frozen;
    int  k;
    bit  done;
    l = p * TD;
    push_model(start, p, kind, at, nsteps);
    frozen = (1 << nsteps) - 1;
    tick();
    check("round_active_start", int'(RoundActive), 1);
    k = 0;
    done = 1'b0;
    while (!done) begin
      if (force_d3) Difficulty = (k >= 10) ? 2'd3 : 2'd0;
      else          Difficulty = 2'($urandom_range(0, 3));
      case (kind)
        K_FULL: begin
          if (k == NL * l + 1) EnableGameElements = 1'b0;
          else if (k == NL * l + 2) begin
            check("full_end_leds",   int'(LEDs), 0);
            check("full_end_active", int'(RoundActive), 0);
            check("full_end_rounds", int'(RoundsPassed), rounds_m);
            done = 1'b1;
          end
        end
        K_CRASH: begin
          if (k == at) CrashDetected = 1'b1;
          else if (k == at + 1) begin
            CrashDetected = 1'b0;
            check("crash_leds_frozen", int'(LEDs), frozen);
            check("crash_active",      int'(RoundActive), 0);
          end else if (k == at + 3) begin
            check("crash_leds_held", int'(LEDs), frozen);
            check("crash_rounds",    int'(RoundsPassed), rounds_m);
            EnableGameElements = 1'b0;
          end else if (k == at + 4) begin
            check("crash_drop_leds", int'(LEDs), 0);
            done = 1'b1;
          end
        end
        K_ABORT: begin
          if (k == at) EnableGameElements = 1'b0;
          else if (k == at + 1) begin
            check("abort_leds",   int'(LEDs), 0);
            check("abort_active", int'(RoundActive), 0);
            done = 1'b1;
          end
        end
        default: begin
          if (k == at) NewGamePulse = 1'b1;
          else if (k == at + 1) begin
            NewGamePulse = 1'b0;
            check("newgame_leds",   int'(LEDs), 0);
            check("newgame_rounds", int'(RoundsPassed), 0);
            check("newgame_active", int'(RoundActive), 0);
            Difficulty = 2'(chain_diff);
            done = 1'b1;
          end
        end
      endcase
      if (!done) begin
        tick();
        k++;
      end
    end
  endtask

  // Raise enable with a given difficulty and play one round; a new-game
  // round chains straight into a full round since enable stays high.
  task automatic do_round(input int diff, input int kind, input int at, input bit force_d3);
    int nd;
    Difficulty = 2'(diff);
    EnableGameElements = 1'b1;
    check("idle_before_start", int'(RoundActive), 0);
    nd = $urandom_range(0, 3);
    play_round(cyc + 1, period_of(diff), kind, at, force_d3, nd);
    if (kind == K_NEWGAME) play_round(cyc + 1, period_of(nd), K_FULL, 0, 1'b0, 0);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic int rand_at(input int diff, input int kind);
    int l;
    int a;
    l = period_of(diff) * TD;
    a = $urandom_range(1, NL * l - 1);
    if (kind == K_ABORT && (a % l) == 0) a = a - 1;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with random inputs.
    repeat (3) begin
      tick();
      check("reset_leds",    int'(LEDs), 0);
      check("reset_timeout", int'(LEDTrackerTimeOut), 0);
      check("reset_active",  int'(RoundActive), 0);
      check("reset_step",    int'(StepPulse), 0);
      check("reset_rounds",  int'(RoundsPassed), 0);
      NewGamePulse       = 1'($urandom_range(0, 1));
      EnableGameElements = 1'($urandom_range(0, 1));
      Difficulty         = 2'($urandom_range(0, 3));
      CrashDetected      = 1'($urandom_range(0, 1));
    end
    NewGamePulse = 1'b0; EnableGameElements = 1'b0; CrashDetected = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    check("post_reset_active", int'(RoundActive), 0);
    check("post_reset_leds",   int'(LEDs), 0);

    // Directed: difficulty 3 full round, difficulty 0 with late change to 3.
    do_round(3, K_FULL, 0, 1'b0);
    check("rounds_after_first", int'(RoundsPassed), 1);
    do_round(0, K_FULL, 0, 1'b1);
    // Crash at cycle 20, and crash on the final step edge.
    do_round(3, K_CRASH, 20, 1'b0);
    do_round(3, K_CRASH, NL * 4 * TD - 1, 1'b0);
    check("rounds_after_crashes", int'(RoundsPassed), 2);

    // Enough passed rounds to saturate the counter.
    for (int r = 0; r < 15; r++) do_round($urandom_range(0, 3), K_FULL, 0, 1'b0);
    check("rounds_saturated", int'(RoundsPassed), 15);

    // Random mix of round outcomes.
    for (int r = 0; r < 12; r++) begin
      int d;
      int kd;
      d  = $urandom_range(0, 3);
      kd = $urandom_range(0, 3);
      do_round(d, kd, rand_at(d, kd), 1'b0);
    end

    // Directed new game mid-round, then the chained round.
    do_round(3, K_NEWGAME, 13, 1'b0);
    check("rounds_after_newgame", int'(RoundsPassed), 1);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
